// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM-stage access unit: RV funct3 access codes,
// FSM state encoding and the access-size decode used by store and load paths.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    // log2 of the access size in bytes; doubleword only exists on 64-bit datapaths
    function automatic logic [1:0] access_size(input logic [2:0] f3, input int xlen);
        case (f3)
            F3_B, F3_BU: return 2'd0;
            F3_H, F3_HU: return 2'd1;
            F3_D:        return (xlen == 64) ? 2'd3 : 2'd2;
            default:     return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load result formatting: shifts the returned word down by the byte offset of
// the access and sign- or zero-extends according to funct3.
// LWU and LD collapse to a plain word load when XLEN is 32.
module mem_load_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  rdata_q,
    input  logic [OFF_W-1:0] offset,
    input  logic [2:0]       funct3,
    output logic [XLEN-1:0]  ReadDataM_Out
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata_q >> {offset, 3'b000};

    // extend the addressed lanes to a full register value
    always_comb begin
        ReadDataM_Out = shifted;
        case (funct3)
            F3_B:    ReadDataM_Out = XLEN'($signed(shifted[7:0]));
            F3_BU:   ReadDataM_Out = XLEN'(shifted[7:0]);
            F3_H:    ReadDataM_Out = XLEN'($signed(shifted[15:0]));
            F3_HU:   ReadDataM_Out = XLEN'(shifted[15:0]);
            F3_W:    ReadDataM_Out = XLEN'($signed(shifted[31:0]));
            F3_WU:   ReadDataM_Out = XLEN'(shifted[31:0]);
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM-stage access unit: issues one req/ack data-memory access per load/store,
// stalls the pipeline while it is outstanding and turns a hung access into a
// one-cycle BusErrM pulse after TIMEOUT_CYC WAIT cycles.
// Build option MEM_MISALIGN_TRAP_EN: misaligned accesses are refused and
// reported on MisalignM; without it the low offset bits are cleared instead.
module mem_stage_hs
    import mem_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     ALUResultM,
    input  logic [XLEN-1:0]     WriteDataM,
    input  logic [2:0]          Funct3M,
    input  logic [4:0]          RdM,
    input  logic                MemReadM,
    input  logic                MemWriteM,
    input  logic                MemToRegM,
    input  logic                RegWriteM,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic [XLEN-1:0]     ReadDataM_Out,
    output logic [XLEN-1:0]     ALUResultM_Out,
    output logic [4:0]          RdM_Out,
    output logic                MemToRegM_Out,
    output logic                RegWriteM_Out,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                MisalignM,
`endif
    output logic                StallM,
    output logic                BusErrM
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   wait_cnt;
    logic [XLEN-1:0]    rdata_q;
    logic [OFF_W-1:0]   off_q;
    logic [2:0]         f3_q;
    logic               abort_q;

    logic               op;
    logic [1:0]         size;
    logic [OFF_W-1:0]   off_raw;
    logic [OFF_W-1:0]   low_mask;
    logic [OFF_W-1:0]   off_eff;
    logic [STRB_W-1:0]  strb_c;
    logic [XLEN-1:0]    wdata_c;
    logic [ADDR_W-1:0]  addr_full;
    logic               misalign;
    logic               misalign_pulse;
    logic               issue;
    logic               ack_take;
    logic               timeout_hit;

    assign op        = MemReadM | MemWriteM;
    assign size      = access_size(Funct3M, XLEN);
    assign off_raw   = ALUResultM[OFF_W-1:0];
    assign low_mask  = OFF_W'((32'd1 << size) - 32'd1);
    // offset bits below the access size are dropped: natural alignment
    assign off_eff   = off_raw & ~low_mask;
    assign strb_c    = STRB_W'((32'd1 << (32'd1 << size)) - 32'd1) << off_eff;
    assign addr_full = ADDR_W'(ALUResultM);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign  = op & (|(off_raw & low_mask));
    assign MisalignM = misalign_pulse;
`else
    assign misalign  = 1'b0;
`endif

    // replicate store data so every lane the strobe may select carries it
    always_comb begin
        wdata_c = WriteDataM;
        case (size)
            2'd0:    wdata_c = {STRB_W{WriteDataM[7:0]}};
            2'd1:    wdata_c = {(STRB_W / 2){WriteDataM[15:0]}};
            2'd2:    wdata_c = {(STRB_W / 4){WriteDataM[31:0]}};
            default: ;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // next state, stall and access control
    always_comb begin
        state_n        = state;
        issue          = 1'b0;
        ack_take       = 1'b0;
        timeout_hit    = 1'b0;
        misalign_pulse = 1'b0;
        StallM         = 1'b0;
        case (state)
            IDLE: begin
                if (misalign) begin
                    misalign_pulse = 1'b1;
                end else if (op) begin
                    issue   = 1'b1;
                    StallM  = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                StallM = 1'b1;
                if (mem_ack) begin
                    ack_take = 1'b1;
                    state_n  = DONE;
                end else if (wait_cnt == CNT_W'(TIMEOUT_CYC)) begin
                    timeout_hit = 1'b1;
                    state_n     = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // bus registers, WAIT-cycle counter (index of the current WAIT cycle) and load capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            wait_cnt  <= '0;
            rdata_q   <= '0;
            off_q     <= '0;
            f3_q      <= '0;
            abort_q   <= 1'b0;
        end else if (issue) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= {addr_full[ADDR_W-1:OFF_W], OFF_W'(0)};
            mem_wdata <= wdata_c;
            mem_wstrb <= MemWriteM ? strb_c : '0;
            wait_cnt  <= CNT_W'(1);
            off_q     <= off_eff;
            f3_q      <= Funct3M;
            abort_q   <= 1'b0;
        end else if (ack_take || timeout_hit) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            wait_cnt  <= '0;
            abort_q   <= timeout_hit;
            if (ack_take) rdata_q <= mem_rdata;
        end else if (state == WAIT) begin
            wait_cnt  <= wait_cnt + CNT_W'(1);
        end
    end

    mem_load_align #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_align (
        .rdata_q       (rdata_q),
        .offset        (off_q),
        .funct3        (f3_q),
        .ReadDataM_Out (ReadDataM_Out)
    );

    assign BusErrM        = (state == DONE) & abort_q;
    assign ALUResultM_Out = ALUResultM;
    assign RdM_Out        = RdM;
    assign MemToRegM_Out  = MemToRegM;
    assign RegWriteM_Out  = RegWriteM & ~BusErrM & ~misalign_pulse;

endmodule
